// File: rtl/adder_pkg.sv
// Shared types and constants for the sync-adder datapath and its result buffer.
package adder_pkg;

    localparam int RES_W = 9;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } fifo_state_e;

endpackage

// File: rtl/adder_result_fifo_if.sv
// Result-buffer handshake bundle: producer side (in_*) and sink side (out_*).
// valid/ready: a word moves when valid & ready are both high at a posedge; valid and data
// hold until accepted, and ready never depends combinationally on valid on the same side.
interface adder_result_fifo_if
    import adder_pkg::*;
#(
    parameter int WIDTH = RES_W
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    // Environment side: controller drives in_*, sink drives out_ready.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // FIFO side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/adder_result_fifo_ptr.sv
// Wrap-around index counter 0..DEPTH-1 with increment enable and sync reset.
module fifo_ptr #(
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Explicit wrap so non-power-of-2 depths work.
    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;
endmodule

// File: rtl/adder_result_fifo.sv
// First-word-fall-through result buffer between the adder controller and its sink;
// back-pressures the controller through in_ready and flags dropped results as overflow.
module adder_result_fifo
    import adder_pkg::*;
#(
    parameter int WIDTH = RES_W,
    parameter int DEPTH = 4,  // legal 2..16
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    adder_result_fifo_if.slave   bus,
    output logic [CNT_W-1:0]     count,
    output fifo_state_e          state,
    output logic                 overflow
);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    fifo_state_e      state_q, state_d;
    logic             is_full, is_empty, push, pop;

    assign is_full  = (count_q == FULL_CNT);
    assign is_empty = (count_q == '0);
    // Handshakes are ignored in the reset cycle.
    assign push     = bus.in_valid & ~is_full & ~rst;
    assign pop      = bus.out_ready & ~is_empty & ~rst;

    fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (.clk(clk), .rst(rst), .inc(pop),  .ptr(rd_ptr));
    fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (.clk(clk), .rst(rst), .inc(push), .ptr(wr_ptr));

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
        overflow_d = overflow_q | (bus.in_valid & is_full);
    end

    // Occupancy FSM follows the next count so it always matches the decode of count.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (push) state_d = PARTIAL;
            PARTIAL: begin
                if (count_d == FULL_CNT) state_d = FULL;
                else if (count_d == '0)  state_d = EMPTY;
            end
            FULL:    if (pop) state_d = PARTIAL;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= EMPTY;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr] <= bus.in_data;
    end

    assign bus.in_ready  = ~is_full;
    assign bus.out_valid = ~is_empty;
    assign bus.out_data  = is_empty ? '0 : mem_q[rd_ptr];
    assign count         = count_q;
    assign state         = state_q;
    assign overflow      = overflow_q;
endmodule

// File: tb/tb_adder_result_fifo.sv
// Bench for adder_result_fifo: table-driven fill/overflow/drain plus queue-model traffic.
module tb_adder_result_fifo;
  import adder_pkg::*;

  localparam int DEPTH = 4;
  localparam int W = RES_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adder_result_fifo_if #(.WIDTH(W)) ifc ();
  logic [2:0]  count;
  fifo_state_e state;
  logic        overflow;

  adder_result_fifo #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(ifc.slave),
    .count(count), .state(state), .overflow(overflow)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0] exp_q[$];   // words the model holds, head first
  logic [W-1:0] rx_q[$];    // words the sink has taken
  bit           exp_ovf;
  bit           last_push;
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic fifo_state_e exp_state();
    if (exp_q.size() == 0) return EMPTY;
    if (exp_q.size() == DEPTH) return FULL;
    return PARTIAL;
  endfunction

  task automatic check_outputs();
    check("count",     32'(count),         32'(exp_q.size()));
    check("in_ready",  32'(ifc.in_ready),  32'(exp_q.size() != DEPTH));
    check("out_valid", 32'(ifc.out_valid), 32'(exp_q.size() != 0));
    check("out_data",  32'(ifc.out_data),  (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
    check("state",     32'(state),         32'(exp_state()));
    check("overflow",  32'(overflow),      32'(exp_ovf));
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit v, input logic [W-1:0] d, input bit r, input bit rs);
    bit push, pop;
    ifc.in_valid  = v;
    ifc.in_data   = d;
    ifc.out_ready = r;
    rst           = rs;
    @(posedge clk);
    push = 1'b0;
    pop  = 1'b0;
    if (rs) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end else begin
      push = v && (exp_q.size() != DEPTH);
      pop  = r && (exp_q.size() != 0);
      if (v && exp_q.size() == DEPTH) exp_ovf = 1'b1;
      if (pop) rx_q.push_back(exp_q.pop_front());
      if (push) exp_q.push_back(d);
    end
    last_push = push;
    #1;
    check_outputs();
  endtask

  // ---------------- table-driven fill / overflow / drain ----------------
  typedef struct {
    bit           v;
    logic [W-1:0] d;
    bit           r;
    int           exp_count;
    logic [W-1:0] exp_data;
    bit           exp_ovf;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int cyc, idx, sent, max_cnt;
    bit tog, saw_block;
    logic [W-1:0] sent_q[$];
    logic [W-1:0] cur;
    logic [7:0] a, b;
    bit have_cur;

    ifc.in_valid = 0; ifc.in_data = '0; ifc.out_ready = 0;
    exp_ovf = 0;

    // Reset state
    cycle(0, '0, 0, 1);
    cycle(0, '0, 0, 1);
    cycle(0, '0, 0, 0);
    check("rst_count", 32'(count), 0);
    check("rst_state", 32'(state), 32'(EMPTY));

    vecs[0] = '{1, 9'h011, 0, 1, 9'h011, 0};
    vecs[1] = '{1, 9'h022, 0, 2, 9'h011, 0};
    vecs[2] = '{1, 9'h033, 0, 3, 9'h011, 0};
    vecs[3] = '{1, 9'h144, 0, 4, 9'h011, 0};
    vecs[4] = '{1, 9'h155, 0, 4, 9'h011, 1};
    vecs[5] = '{0, 9'h000, 1, 3, 9'h022, 1};
    vecs[6] = '{0, 9'h000, 1, 2, 9'h033, 1};
    vecs[7] = '{0, 9'h000, 1, 1, 9'h144, 1};
    vecs[8] = '{0, 9'h000, 1, 0, 9'h000, 1};
    vecs[9] = '{0, 9'h000, 1, 0, 9'h000, 1};
    rx_q.delete();
    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].v, vecs[i].d, vecs[i].r, 0);
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_data", i),  32'(ifc.out_data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_ovf", i),   32'(overflow), 32'(vecs[i].exp_ovf));
      if (i == 3) begin
        check("full_state", 32'(state), 32'(FULL));
        check("full_in_ready", 32'(ifc.in_ready), 0);
      end
    end
    check("drain_len", 32'(rx_q.size()), 4);
    if (rx_q.size() == 4) begin
      check("drain0", 32'(rx_q[0]), 32'h011);
      check("drain1", 32'(rx_q[1]), 32'h022);
      check("drain2", 32'(rx_q[2]), 32'h033);
      check("drain3", 32'(rx_q[3]), 32'h144);
    end

    // Simultaneous push/pop holding count at 2
    rx_q.delete();
    cycle(1, 9'h0a1, 0, 0);
    cycle(1, 9'h0b2, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 9'(9'h0c0 + i), 1, 0);
      check("simul_count", 32'(count), 2);
    end
    cyc = 0;
    while (count != 0 && cyc < 20) begin cycle(0, '0, 1, 0); cyc++; end
    check("simul_len", 32'(rx_q.size()), 7);
    if (rx_q.size() == 7) begin
      check("simul0", 32'(rx_q[0]), 32'h0a1);
      check("simul1", 32'(rx_q[1]), 32'h0b2);
      for (int i = 0; i < 5; i++) check("simul_n", 32'(rx_q[2+i]), 32'(9'h0c0 + i));
    end

    // Reset mid-traffic: held entries and overflow cleared, handshakes ignored
    cycle(1, 9'h101, 0, 0);
    cycle(1, 9'h102, 0, 0);
    cycle(1, 9'h103, 1, 1);
    cycle(1, 9'h104, 1, 1);
    cycle(0, '0, 1, 0);
    check("rst2_count", 32'(count), 0);
    check("rst2_state", 32'(state), 32'(EMPTY));
    check("rst2_in_ready", 32'(ifc.in_ready), 1);
    check("rst2_out_valid", 32'(ifc.out_valid), 0);
    check("rst2_out_data", 32'(ifc.out_data), 0);
    check("rst2_overflow", 32'(overflow), 0);

    // Wrap-around: stream 0..9 with out_ready toggling
    rx_q.delete();
    idx = 0; cyc = 0; tog = 1; max_cnt = 0;
    while ((idx < 10 || exp_q.size() != 0) && cyc < 200) begin
      cycle(idx < 10, 9'(idx), tog, 0);
      if (last_push) idx++;
      if (int'(count) > max_cnt) max_cnt = int'(count);
      tog = !tog;
      cyc++;
    end
    check("wrap_timeout", 32'(cyc >= 200), 0);
    check("wrap_max_count", 32'(max_cnt <= DEPTH), 1);
    check("wrap_len", 32'(rx_q.size()), 10);
    for (int i = 0; i < 10 && i < rx_q.size(); i++) check("wrap_word", 32'(rx_q[i]), 32'(i));

    // Controller loop: sums held until accepted, sink stalls 8 cycles
    rx_q.delete();
    sent_q.delete();
    sent = 0; cyc = 0; saw_block = 0; have_cur = 0; cur = '0;
    while ((sent < 12 || exp_q.size() != 0) && cyc < 300) begin
      if (!have_cur && sent < 12) begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        cur = {1'b0, a} + {1'b0, b};
        have_cur = 1;
      end
      cycle(have_cur, cur, cyc >= 8, 0);
      if (last_push) begin sent_q.push_back(cur); sent++; have_cur = 0; end
      if (cyc < 8 && !ifc.in_ready) saw_block = 1;
      cyc++;
    end
    check("ctrl_timeout", 32'(cyc >= 300), 0);
    check("ctrl_backpressure", 32'(saw_block), 1);
    check("ctrl_len", 32'(rx_q.size()), 12);
    for (int i = 0; i < 12 && i < rx_q.size(); i++) check("ctrl_word", 32'(rx_q[i]), 32'(sent_q[i]));

    // Random traffic with occasional two-cycle resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        cycle($urandom_range(0, 1) == 1, 9'($urandom_range(0, 511)), 1, 1);
        cycle($urandom_range(0, 1) == 1, 9'($urandom_range(0, 511)), 1, 1);
      end else begin
        cycle($urandom_range(0, 2) != 0, 9'($urandom_range(0, 511)),
              $urandom_range(0, 2) == 0, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
